// File: rtl/blood_ph_monitor.sv
// Blood-pH monitor: classifies each valid sample as LOW / NORMAL / HIGH and
// filters the class through a persistence/recovery FSM, so isolated outliers
// never raise an alarm. Alarm entries are counted and latched until acknowledged.
module blood_ph_monitor #(
  parameter int PH_W      = 4,
  parameter int LOW_TH    = 7,
  parameter int HIGH_TH   = 8,
  parameter int PERSIST   = 3,
  parameter int CLEAR_CNT = 2,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PH_W-1:0]  ph_sample,
  input  logic             sample_valid,
  input  logic             fault_ack,
  output logic             alarm_low,
  output logic             alarm_high,
  output logic             latched_fault,
  output logic [CNT_W-1:0] event_count,
  output logic [PH_W-1:0]  ph_last
);

  localparam int MAX_CNT = (PERSIST > CLEAR_CNT) ? PERSIST : CLEAR_CNT;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [PH_W-1:0] LOW_C     = PH_W'(LOW_TH);
  localparam logic [PH_W-1:0] HIGH_C    = PH_W'(HIGH_TH);
  localparam logic [CW-1:0]   PERSIST_C = CW'(PERSIST);
  localparam logic [CW-1:0]   CLEAR_C   = CW'(CLEAR_CNT);
  localparam logic [CW-1:0]   ONE_C     = CW'(1);
  localparam bit              PERSIST_1 = (PERSIST == 1);
  localparam bit              CLEAR_1   = (CLEAR_CNT == 1);

  typedef enum logic [2:0] {
    S_NORMAL,
    S_PEND_LOW,
    S_PEND_HIGH,
    S_ALARM_LOW,
    S_ALARM_HIGH,
    S_RECOVER_LOW,
    S_RECOVER_HIGH
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nx;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_entry;
  logic             w_is_low;
  logic             w_is_high;
  logic             r_fault;
  logic [CNT_W-1:0] r_events;
  logic [PH_W-1:0]  r_ph_last;

  // Sample classification; values equal to a threshold are NORMAL
  always_comb begin
    w_is_low  = (ph_sample < LOW_C);
    w_is_high = (ph_sample > HIGH_C);
    w_cnt_inc = r_cnt + ONE_C;
  end

  // Next-state / persistence-counter logic
  // Every "start pending" path shares one rule: with PERSIST=1 the first
  // out-of-range sample is already an alarm entry, otherwise pend with cnt=1.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_entry    = 1'b0;
    if (sample_valid) begin
      case (r_state)
        S_NORMAL, S_PEND_LOW, S_PEND_HIGH: begin
          if (w_is_low) begin
            if (r_state == S_PEND_LOW && w_cnt_inc != PERSIST_C) begin
              w_cnt_nx = w_cnt_inc;
            end else if (r_state == S_PEND_LOW || PERSIST_1) begin
              w_state_nx = S_ALARM_LOW;
              w_cnt_nx   = '0;
              w_entry    = 1'b1;
            end else begin
              w_state_nx = S_PEND_LOW;
              w_cnt_nx   = ONE_C;
            end
          end else if (w_is_high) begin
            if (r_state == S_PEND_HIGH && w_cnt_inc != PERSIST_C) begin
              w_cnt_nx = w_cnt_inc;
            end else if (r_state == S_PEND_HIGH || PERSIST_1) begin
              w_state_nx = S_ALARM_HIGH;
              w_cnt_nx   = '0;
              w_entry    = 1'b1;
            end else begin
              w_state_nx = S_PEND_HIGH;
              w_cnt_nx   = ONE_C;
            end
          end else begin
            w_state_nx = S_NORMAL;
            w_cnt_nx   = '0;
          end
        end
        S_ALARM_LOW, S_RECOVER_LOW: begin
          if (w_is_low) begin
            w_state_nx = S_ALARM_LOW;
            w_cnt_nx   = '0;
          end else if (w_is_high) begin
            if (PERSIST_1) begin
              w_state_nx = S_ALARM_HIGH;
              w_cnt_nx   = '0;
              w_entry    = 1'b1;
            end else begin
              w_state_nx = S_PEND_HIGH;
              w_cnt_nx   = ONE_C;
            end
          end else if (CLEAR_1 ||
                       (r_state == S_RECOVER_LOW && w_cnt_inc == CLEAR_C)) begin
            w_state_nx = S_NORMAL;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = S_RECOVER_LOW;
            w_cnt_nx   = (r_state == S_RECOVER_LOW) ? w_cnt_inc : ONE_C;
          end
        end
        S_ALARM_HIGH, S_RECOVER_HIGH: begin
          if (w_is_high) begin
            w_state_nx = S_ALARM_HIGH;
            w_cnt_nx   = '0;
          end else if (w_is_low) begin
            if (PERSIST_1) begin
              w_state_nx = S_ALARM_LOW;
              w_cnt_nx   = '0;
              w_entry    = 1'b1;
            end else begin
              w_state_nx = S_PEND_LOW;
              w_cnt_nx   = ONE_C;
            end
          end else if (CLEAR_1 ||
                       (r_state == S_RECOVER_HIGH && w_cnt_inc == CLEAR_C)) begin
            w_state_nx = S_NORMAL;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = S_RECOVER_HIGH;
            w_cnt_nx   = (r_state == S_RECOVER_HIGH) ? w_cnt_inc : ONE_C;
          end
        end
        default: begin
          w_state_nx = S_NORMAL;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  // State, counter and last-sample registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_NORMAL;
      r_cnt     <= '0;
      r_ph_last <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (sample_valid) begin
        r_ph_last <= ph_sample;
      end
    end
  end

  // Event counter (saturating) and sticky fault; a new entry beats an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      r_events <= '0;
      r_fault  <= 1'b0;
    end else begin
      if (w_entry && r_events != '1) begin
        r_events <= r_events + CNT_W'(1);
      end
      if (w_entry) begin
        r_fault <= 1'b1;
      end else if (fault_ack) begin
        r_fault <= 1'b0;
      end
    end
  end

  // Alarm outputs decode directly from the registered state
  always_comb begin
    alarm_low     = (r_state == S_ALARM_LOW)  || (r_state == S_RECOVER_LOW);
    alarm_high    = (r_state == S_ALARM_HIGH) || (r_state == S_RECOVER_HIGH);
    latched_fault = r_fault;
    event_count   = r_events;
    ph_last       = r_ph_last;
  end

endmodule

// File: tb/tb_blood_ph_monitor.sv
// Directed bench for blood_ph_monitor with default parameters.
module tb_blood_ph_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] ph_sample = '0;
  logic       sample_valid = 1'b0;
  logic       fault_ack = 1'b0;
  logic       alarm_low;
  logic       alarm_high;
  logic       latched_fault;
  logic [3:0] event_count;
  logic [3:0] ph_last;

  int checks = 0;
  int errors = 0;
  int exp_ev = 0;

  blood_ph_monitor #(
    .PH_W(4), .LOW_TH(7), .HIGH_TH(8), .PERSIST(3), .CLEAR_CNT(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .ph_sample(ph_sample), .sample_valid(sample_valid),
    .fault_ack(fault_ack), .alarm_low(alarm_low), .alarm_high(alarm_high),
    .latched_fault(latched_fault), .event_count(event_count), .ph_last(ph_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input bit v, input int d, input bit ack);
    @(negedge clk);
    sample_valid = v;
    ph_sample    = 4'(d);
    fault_ack    = ack;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    fault_ack    = 1'b0;
    check("never_both", int'(alarm_low & alarm_high), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int lo, input int hi,
                            input int flt, input int ev);
    check({tag, "_alarm_low"}, int'(alarm_low), lo);
    check({tag, "_alarm_high"}, int'(alarm_high), hi);
    check({tag, "_fault"}, int'(latched_fault), flt);
    check({tag, "_events"}, int'(event_count), ev);
  endtask

  initial begin
    // Reset held two cycles
    do_reset(2);
    expect_out("reset", 0, 0, 0, 0);
    check("reset_ph_last", int'(ph_last), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 6, 1'b0);
    expect_out("idle", 0, 0, 0, 0);
    check("idle_ph_last", int'(ph_last), 0);

    // 6,6,6 raises the low alarm on the third sample
    step(1'b1, 6, 1'b0); check("p1_low", int'(alarm_low), 0);
    step(1'b1, 6, 1'b0); check("p2_low", int'(alarm_low), 0);
    step(1'b1, 6, 1'b0);
    expect_out("entry_low", 1, 0, 1, 1);
    check("entry_ph_last", int'(ph_last), 6);

    // Recovery: 7,7 clears after the second normal sample
    step(1'b1, 7, 1'b0); check("rec1_low", int'(alarm_low), 1);
    step(1'b1, 7, 1'b0); expect_out("rec2", 0, 0, 1, 1);

    // Re-enter, then 7,6 returns to alarm without a new event
    for (int i = 0; i < 3; i++) step(1'b1, 6, 1'b0);
    expect_out("entry2", 1, 0, 1, 2);
    step(1'b1, 7, 1'b0); check("rec_hold_low", int'(alarm_low), 1);
    step(1'b1, 6, 1'b0); expect_out("rec_back", 1, 0, 1, 2);

    // Ack alone clears the sticky fault
    step(1'b0, 0, 1'b1); check("ack_clear", int'(latched_fault), 0);

    // Back to NORMAL, then 6,6,7 must not alarm
    step(1'b1, 7, 1'b0); step(1'b1, 7, 1'b0);
    step(1'b1, 6, 1'b0); step(1'b1, 6, 1'b0); step(1'b1, 7, 1'b0);
    expect_out("no_alarm_667", 0, 0, 0, 2);

    // 15, five idle cycles with data 0, then 15,15
    step(1'b1, 15, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);
    check("gap_ph_last", int'(ph_last), 15);
    check("gap_high", int'(alarm_high), 0);
    step(1'b1, 15, 1'b0); check("gap2_high", int'(alarm_high), 0);
    step(1'b1, 15, 1'b0);
    expect_out("entry_high", 0, 1, 1, 3);
    check("high_ph_last", int'(ph_last), 15);

    // Opposite class drops the alarm; alternating samples never alarm
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6, 1'b0); expect_out("alt6", 0, 0, 1, 3);
      step(1'b1, 9, 1'b0); expect_out("alt9", 0, 0, 1, 3);
    end

    // Threshold values are NORMAL
    for (int i = 0; i < 3; i++) step(1'b1, 7, 1'b0);
    expect_out("bound7", 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) step(1'b1, 8, 1'b0);
    expect_out("bound8", 0, 0, 1, 3);

    // Ack coincident with entry: set wins
    step(1'b0, 0, 1'b1); check("ack_clear2", int'(latched_fault), 0);
    step(1'b1, 6, 1'b0); step(1'b1, 6, 1'b0);
    step(1'b1, 6, 1'b1);
    expect_out("ack_vs_entry", 1, 0, 1, 4);
    exp_ev = 4;

    // Alternate high/low alarm entries until the counter saturates
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 3; j++) step(1'b1, 12, 1'b0);
      exp_ev = (exp_ev < 15) ? exp_ev + 1 : 15;
      expect_out("sat_high", 0, 1, 1, exp_ev);
      for (int j = 0; j < 3; j++) step(1'b1, 2, 1'b0);
      exp_ev = (exp_ev < 15) ? exp_ev + 1 : 15;
      expect_out("sat_low", 1, 0, 1, exp_ev);
    end
    check("saturated", int'(event_count), 15);

    // Reset while pending discards the partial count
    step(1'b1, 7, 1'b0); step(1'b1, 7, 1'b0);
    step(1'b1, 6, 1'b0); step(1'b1, 6, 1'b0);
    do_reset(1);
    expect_out("mid_reset", 0, 0, 0, 0);
    check("mid_reset_ph_last", int'(ph_last), 0);
    step(1'b1, 6, 1'b0); check("after_rst1", int'(alarm_low), 0);
    step(1'b1, 6, 1'b0); check("after_rst2", int'(alarm_low), 0);
    step(1'b1, 6, 1'b0); expect_out("after_rst3", 1, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
